shift_universal: RTL and testbench

//   Parametrised successor to the single-bit left shifter. Holds a width_p-bit

---
 rtl/shift_universal.sv | 92 +++++++++
 tb/tb_shift_universal.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shift_universal.sv
// shift_universal: universal shift/rotate register with a burst engine that repeats a latched shift op for len_i steps
module shift_universal #(
  parameter int width_p = 8,
  parameter int max_amt_p = 4,
  parameter int len_width_p = 4,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [2:0]                         op_i,
  input  logic [$clog2(max_amt_p+1)-1:0]     amt_i,
  input  logic [max_amt_p-1:0]               fill_i,
  input  logic [width_p-1:0]                 data_i,
  input  logic                               start_i,
  input  logic [len_width_p-1:0]             len_i,
  output logic [width_p-1:0]                 data_o,
  output logic [max_amt_p-1:0]               sout_o,
  output logic                               busy_o,
  output logic                               done_o
);
  localparam int w_lp = width_p;
  localparam int m_lp = max_amt_p;
  localparam int aw_lp = $clog2(max_amt_p+1);
  localparam logic [aw_lp-1:0] max_amt_lp = aw_lp'(max_amt_p);
  localparam logic [2:0] op_hold = 3'd0, op_load = 3'd1, op_shl = 3'd2, op_rol = 3'd4, op_ror = 3'd5, op_asr = 3'd6;
  localparam logic idle_s = 1'b0, busy_s = 1'b1;
  logic [w_lp-1:0] data_q, data_d;
  logic [m_lp-1:0] sout_q, sout_d;
  logic state_q, state_d, done_q, done_d;
  logic [2:0] op_q, op_d, sel_op;
  logic [aw_lp-1:0] amt_q, amt_d, amt_c, sel_amt;
  logic [len_width_p-1:0] len_q, len_d;
  logic start_burst, shifting, last_step;
  logic [m_lp-1:0] fill_hi, lo_mask, hi_out, lo_out;
  logic [w_lp+m_lp-1:0] shl_c, shr_c;
  logic [2*w_lp-1:0] rol_c, ror_c;
  logic [w_lp-1:0] asr_c;
  assign amt_c = (amt_i > max_amt_lp) ? max_amt_lp : amt_i;
  assign start_burst = state_q == idle_s && start_i && op_i >= op_shl && op_i <= op_asr;
  assign last_step = state_q == busy_s && len_q <= len_width_p'(1);
  // a zero-length burst still occupies one BUSY cycle, just without shifting
  assign sel_op = state_q == busy_s ? (len_q == '0 ? op_hold : op_q) : (start_burst ? op_hold : op_i);
  assign sel_amt = state_q == busy_s ? amt_q : amt_c;
  assign shifting = sel_op >= op_shl && sel_op <= op_asr && sel_amt != '0;
  // fill_i[a-1:0] is moved to the top so it lands in the vacated low bits after the left shift
  assign fill_hi = fill_i << (m_lp - int'(sel_amt));
  assign shl_c = {data_q, fill_hi} << sel_amt;
  assign shr_c = {fill_i, data_q} >> sel_amt;
  assign rol_c = {data_q, data_q} << sel_amt;
  assign ror_c = {data_q, data_q} >> sel_amt;
  assign asr_c = $signed(data_q) >>> sel_amt;
  assign lo_mask = m_lp'((1 << sel_amt) - 1);
  assign hi_out = m_lp'(data_q >> (w_lp - int'(sel_amt)));
  assign lo_out = data_q[m_lp-1:0] & lo_mask;
  always_comb begin
    data_d = sel_op == op_load ? data_i :
             !shifting ? data_q :
             sel_op == op_shl ? shl_c[w_lp+m_lp-1:m_lp] :
             sel_op == op_rol ? rol_c[2*w_lp-1:w_lp] :
             sel_op == op_ror ? ror_c[w_lp-1:0] :
             sel_op == op_asr ? asr_c : shr_c[w_lp-1:0];
    sout_d = !shifting ? sout_q : (sel_op == op_shl || sel_op == op_rol) ? hi_out : lo_out;
    state_d = start_burst ? busy_s : last_step ? idle_s : state_q;
    len_d = start_burst ? len_i : (state_q == busy_s && len_q != '0) ? len_q - 1'b1 : len_q;
    op_d = start_burst ? op_i : op_q;
    amt_d = start_burst ? amt_c : amt_q;
    done_d = last_step;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_q <= reset_val_p;
      sout_q <= '0;
      state_q <= idle_s;
      done_q <= 1'b0;
      op_q <= op_hold;
      amt_q <= '0;
      len_q <= '0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      state_q <= state_d;
      done_q <= done_d;
      op_q <= op_d;
      amt_q <= amt_d;
      len_q <= len_d;
    end
  end
  assign data_o = data_q;
  assign sout_o = sout_q;
  assign busy_o = state_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_shift_universal.sv
// tb_shift_universal: directed self-checking bench for shift_universal
module tb_shift_universal;
  logic clk_i = 1'b0;
  logic reset_ni;
  logic [2:0] op_i;
  logic [2:0] amt_i;
  logic [3:0] fill_i;
  logic [7:0] data_i;
  logic start_i;
  logic [3:0] len_i;
  logic [7:0] data_o;
  logic [3:0] sout_o;
  logic busy_o, done_o;
  int errors = 0;
  int checks = 0;
  shift_universal #(.width_p(8), .max_amt_p(4), .len_width_p(4), .reset_val_p(8'hA5)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .op_i(op_i), .amt_i(amt_i), .fill_i(fill_i),
    .data_i(data_i), .start_i(start_i), .len_i(len_i), .data_o(data_o), .sout_o(sout_o),
    .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk_data(input string name, input logic [7:0] exp);
    checks++;
    if (data_o !== exp) begin errors++; $display("FAIL %s: data_o=%h expected %h", name, data_o, exp); end
  endtask
  task automatic chk_ctl(input string name, input logic exp_busy, input logic exp_done);
    checks++;
    if ({busy_o, done_o} !== {exp_busy, exp_done}) begin
      errors++; $display("FAIL %s: busy/done=%b%b expected %b%b", name, busy_o, done_o, exp_busy, exp_done);
    end
  endtask
  task automatic load(input logic [7:0] v);
    op_i = 3'd1; data_i = v; start_i = 1'b0;
    tick();
    op_i = 3'd0;
  endtask
  task automatic test_reset();
    reset_ni = 1'b0; op_i = 3'd1; data_i = 8'h3C; amt_i = 3'd0; fill_i = 4'h0; start_i = 1'b1; len_i = 4'd2;
    tick();
    chk_data("reset_data", 8'hA5);
    checks++;
    if (sout_o !== 4'h0) begin errors++; $display("FAIL reset_sout: sout_o=%h expected 0", sout_o); end
    chk_ctl("reset_ctl", 1'b0, 1'b0);
    reset_ni = 1'b1; op_i = 3'd0; start_i = 1'b0;
    tick();
    chk_data("hold_after_reset", 8'hA5);
  endtask
  task automatic test_single_ops();
    load(8'b1001_0110);
    chk_data("load", 8'b1001_0110);
    op_i = 3'd2; amt_i = 3'd3; fill_i = 4'b0101;
    tick();
    chk_data("shl3", 8'b1011_0101);
    checks++;
    if (sout_o !== 4'b0100) begin errors++; $display("FAIL shl3_sout: sout_o=%b expected 0100", sout_o); end
    load(8'b1001_0110);
    checks++;
    if (sout_o !== 4'b0100) begin errors++; $display("FAIL sout_kept: sout_o=%b expected 0100", sout_o); end
    op_i = 3'd6; amt_i = 3'd2;
    tick();
    chk_data("asr2", 8'b1110_0101);
    load(8'b1001_0110);
    op_i = 3'd5; amt_i = 3'd4;
    tick();
    chk_data("ror4", 8'b0110_1001);
    checks++;
    if (sout_o !== 4'b0110) begin errors++; $display("FAIL ror4_sout: sout_o=%b expected 0110", sout_o); end
    op_i = 3'd4; amt_i = 3'd0;
    tick();
    chk_data("rol_a0_hold", 8'b0110_1001);
    op_i = 3'd3; amt_i = 3'd1; fill_i = 4'b0001;
    tick();
    chk_data("shr1", 8'b1011_0100);
    op_i = 3'd7;
    tick();
    chk_data("reserved_hold", 8'b1011_0100);
    op_i = 3'd0;
  endtask
  task automatic test_clamp();
    load(8'hF0);
    op_i = 3'd3; amt_i = 3'd7; fill_i = 4'h0;
    tick();
    chk_data("shr_clamp", 8'h0F);
    checks++;
    if (sout_o !== 4'h0) begin errors++; $display("FAIL clamp_sout: sout_o=%h expected 0", sout_o); end
    op_i = 3'd0;
  endtask
  task automatic test_burst();
    load(8'h01);
    op_i = 3'd4; amt_i = 3'd1; len_i = 4'd3; start_i = 1'b1;
    tick();
    chk_data("burst_start", 8'h01);
    chk_ctl("burst_start_ctl", 1'b1, 1'b0);
    op_i = 3'd1; data_i = 8'hFF; amt_i = 3'd3; start_i = 1'b1; len_i = 4'd9;
    tick();
    chk_data("burst_s1", 8'h02);
    chk_ctl("burst_s1_ctl", 1'b1, 1'b0);
    tick();
    chk_data("burst_s2", 8'h04);
    chk_ctl("burst_s2_ctl", 1'b1, 1'b0);
    op_i = 3'd0; start_i = 1'b0;
    tick();
    chk_data("burst_s3", 8'h08);
    chk_ctl("burst_done", 1'b0, 1'b1);
    tick();
    chk_data("burst_after", 8'h08);
    chk_ctl("burst_done_pulse", 1'b0, 1'b0);
  endtask
  task automatic test_edges();
    op_i = 3'd4; amt_i = 3'd1; len_i = 4'd0; start_i = 1'b1;
    tick();
    chk_ctl("len0_busy", 1'b1, 1'b0);
    op_i = 3'd0; start_i = 1'b0;
    tick();
    chk_data("len0_data", 8'h08);
    chk_ctl("len0_done", 1'b0, 1'b1);
    tick();
    chk_ctl("len0_idle", 1'b0, 1'b0);
    op_i = 3'd1; data_i = 8'h3C; start_i = 1'b1; len_i = 4'd5;
    tick();
    chk_data("start_load", 8'h3C);
    chk_ctl("start_load_ctl", 1'b0, 1'b0);
    op_i = 3'd0; start_i = 1'b0;
    tick();
    chk_ctl("start_load_idle", 1'b0, 1'b0);
  endtask
  task automatic test_reset_mid_burst();
    load(8'hFF);
    op_i = 3'd2; amt_i = 3'd1; fill_i = 4'h0; len_i = 4'd8; start_i = 1'b1;
    tick();
    op_i = 3'd0; start_i = 1'b0;
    tick();
    tick();
    chk_data("mid_burst_2steps", 8'hFC);
    reset_ni = 1'b0;
    tick();
    chk_data("mid_reset_data", 8'hA5);
    chk_ctl("mid_reset_ctl", 1'b0, 1'b0);
    reset_ni = 1'b1;
    tick();
    chk_ctl("mid_reset_nodone", 1'b0, 1'b0);
    chk_data("mid_reset_hold", 8'hA5);
  endtask
  initial begin
    test_reset();
    test_single_ops();
    test_clamp();
    test_burst();
    test_edges();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
